// File: rtl/dispatcher.sv
// Dispatcher: renames destination registers to tags, captures operands and issues to a reservation station.
// Define DISPATCH_STATS_EN to add saturating statIssued/statStalls counters.
module dispatcher #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              decValid,
  output logic              decReady,
  input  logic [5:0]        decOp,
  input  logic [DATA_W-1:0] decImm,
  input  logic [4:0]        decRs1,
  input  logic [4:0]        decRs2,
  input  logic [4:0]        decRd,
  output logic [4:0]        regNameO,
  output logic [4:0]        regNameT,
  input  logic [DATA_W-1:0] regDataO,
  input  logic [DATA_W-1:0] regDataT,
  input  logic [TAG_W-1:0]  regTagO,
  input  logic [TAG_W-1:0]  regTagT,
  output logic              enWrtDec,
  output logic [TAG_W-1:0]  wrtTagDec,
  output logic [4:0]        wrtNameDec,
  input  logic              ALUwrtEn,
  input  logic              LSwrtEn,
  input  logic [TAG_W-1:0]  ALUwrtTag,
  input  logic [TAG_W-1:0]  LSwrtTag,
  input  logic [DATA_W-1:0] ALUwrtData,
  input  logic [DATA_W-1:0] LSwrtData,
  output logic              rsValid,
  input  logic              rsReady,
  output logic [5:0]        rsOp,
  output logic [DATA_W-1:0] rsImm,
  output logic [DATA_W-1:0] rsDataO,
  output logic [DATA_W-1:0] rsDataT,
  output logic [TAG_W-1:0]  rsTagO,
  output logic [TAG_W-1:0]  rsTagT,
  output logic [TAG_W-1:0]  rsDestTag
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]       statIssued,
  output logic [31:0]       statStalls
`endif
);

  localparam int NUM_TAGS = (1 << TAG_W) - 1;
  localparam logic [TAG_W-1:0] TAG_FREE = '1;

  logic [NUM_TAGS-1:0] freeMap_q, freeMap_d;
  logic                rsValid_q, rsValid_d;
  logic [5:0]          rsOp_q, rsOp_d;
  logic [DATA_W-1:0]   rsImm_q, rsImm_d;
  logic [DATA_W-1:0]   rsDataO_q, rsDataO_d;
  logic [DATA_W-1:0]   rsDataT_q, rsDataT_d;
  logic [TAG_W-1:0]    rsTagO_q, rsTagO_d;
  logic [TAG_W-1:0]    rsTagT_q, rsTagT_d;
  logic [TAG_W-1:0]    rsDestTag_q, rsDestTag_d;

  logic [TAG_W-1:0]    allocTag;
  logic                accept;
  logic                allocate;

  assign regNameO   = decRs1;
  assign regNameT   = decRs2;
  assign decReady   = !rst && (!rsValid_q || rsReady) && ((decRd == 5'd0) || (|freeMap_q));
  assign accept     = decValid && decReady;
  assign allocate   = accept && (decRd != 5'd0);
  assign enWrtDec   = allocate;
  assign wrtTagDec  = allocate ? allocTag : TAG_FREE;
  assign wrtNameDec = allocate ? decRd : 5'd0;

  assign rsValid   = rsValid_q;
  assign rsOp      = rsOp_q;
  assign rsImm     = rsImm_q;
  assign rsDataO   = rsDataO_q;
  assign rsDataT   = rsDataT_q;
  assign rsTagO    = rsTagO_q;
  assign rsTagT    = rsTagT_q;
  assign rsDestTag = rsDestTag_q;

  // Lowest-index free tag wins; scanning downward leaves the lowest one last.
  always_comb begin
    allocTag = TAG_FREE;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (freeMap_q[i]) allocTag = TAG_W'(i);
    end
  end

  // Resolves one operand against this cycle's broadcasts; ALU beats LS when both match.
  function automatic logic [DATA_W+TAG_W-1:0] capture(
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] readyData,
    input logic [DATA_W-1:0] missData
  );
    if (tag == TAG_FREE) return {readyData, TAG_FREE};
    if (ALUwrtEn && (ALUwrtTag == tag)) return {ALUwrtData, TAG_FREE};
    if (LSwrtEn && (LSwrtTag == tag)) return {LSwrtData, TAG_FREE};
    return {missData, tag};
  endfunction

  always_comb begin
    freeMap_d   = freeMap_q;
    rsValid_d   = rsValid_q;
    rsOp_d      = rsOp_q;
    rsImm_d     = rsImm_q;
    rsDataO_d   = rsDataO_q;
    rsDataT_d   = rsDataT_q;
    rsTagO_d    = rsTagO_q;
    rsTagT_d    = rsTagT_q;
    rsDestTag_d = rsDestTag_q;

    if (accept) begin
      rsValid_d              = 1'b1;
      rsOp_d                 = decOp;
      rsImm_d                = decImm;
      {rsDataO_d, rsTagO_d}  = capture(regTagO, regDataO, '0);
      {rsDataT_d, rsTagT_d}  = capture(regTagT, regDataT, '0);
      rsDestTag_d            = allocate ? allocTag : TAG_FREE;
    end else begin
      if (rsReady) rsValid_d = 1'b0;
      {rsDataO_d, rsTagO_d}  = capture(rsTagO_q, rsDataO_q, rsDataO_q);
      {rsDataT_d, rsTagT_d}  = capture(rsTagT_q, rsDataT_q, rsDataT_q);
    end

    // Releases are applied after the allocation so a tag freed now is only reusable next cycle.
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (allocate && (allocTag == TAG_W'(i))) freeMap_d[i] = 1'b0;
      if ((ALUwrtEn && (ALUwrtTag == TAG_W'(i))) || (LSwrtEn && (LSwrtTag == TAG_W'(i))))
        freeMap_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freeMap_q   <= '1;
      rsValid_q   <= 1'b0;
      rsOp_q      <= '0;
      rsImm_q     <= '0;
      rsDataO_q   <= '0;
      rsDataT_q   <= '0;
      rsTagO_q    <= TAG_FREE;
      rsTagT_q    <= TAG_FREE;
      rsDestTag_q <= TAG_FREE;
    end else begin
      freeMap_q   <= freeMap_d;
      rsValid_q   <= rsValid_d;
      rsOp_q      <= rsOp_d;
      rsImm_q     <= rsImm_d;
      rsDataO_q   <= rsDataO_d;
      rsDataT_q   <= rsDataT_d;
      rsTagO_q    <= rsTagO_d;
      rsTagT_q    <= rsTagT_d;
      rsDestTag_q <= rsDestTag_d;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] statIssued_q, statStalls_q;

  assign statIssued = statIssued_q;
  assign statStalls = statStalls_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      statIssued_q <= '0;
      statStalls_q <= '0;
    end else begin
      if (accept && (statIssued_q != '1)) statIssued_q <= statIssued_q + 32'd1;
      if (decValid && !decReady && (statStalls_q != '1)) statStalls_q <= statStalls_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: directed scenarios plus randomized traffic against a tag-pool model.
module tb_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        decValid, decReady;
  logic [5:0]  decOp;
  logic [31:0] decImm;
  logic [4:0]  decRs1, decRs2, decRd;
  logic [4:0]  regNameO, regNameT;
  logic [31:0] regDataO, regDataT;
  logic [3:0]  regTagO, regTagT;
  logic        enWrtDec;
  logic [3:0]  wrtTagDec;
  logic [4:0]  wrtNameDec;
  logic        ALUwrtEn, LSwrtEn;
  logic [3:0]  ALUwrtTag, LSwrtTag;
  logic [31:0] ALUwrtData, LSwrtData;
  logic        rsValid, rsReady;
  logic [5:0]  rsOp;
  logic [31:0] rsImm, rsDataO, rsDataT;
  logic [3:0]  rsTagO, rsTagT, rsDestTag;
`ifdef DISPATCH_STATS_EN
  logic [31:0] statIssued, statStalls;
  int unsigned mIssued, mStalls;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: a pool of free tags plus the single issue slot.
  bit          mFree[15];
  bit          mValid;
  logic [5:0]  mOp;
  logic [31:0] mImm, mDataO, mDataT;
  logic [3:0]  mTagO, mTagT, mDest;

  dispatcher #(.TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .decValid(decValid), .decReady(decReady),
    .decOp(decOp), .decImm(decImm), .decRs1(decRs1), .decRs2(decRs2), .decRd(decRd),
    .regNameO(regNameO), .regNameT(regNameT),
    .regDataO(regDataO), .regDataT(regDataT), .regTagO(regTagO), .regTagT(regTagT),
    .enWrtDec(enWrtDec), .wrtTagDec(wrtTagDec), .wrtNameDec(wrtNameDec),
    .ALUwrtEn(ALUwrtEn), .LSwrtEn(LSwrtEn), .ALUwrtTag(ALUwrtTag), .LSwrtTag(LSwrtTag),
    .ALUwrtData(ALUwrtData), .LSwrtData(LSwrtData),
    .rsValid(rsValid), .rsReady(rsReady),
    .rsOp(rsOp), .rsImm(rsImm), .rsDataO(rsDataO), .rsDataT(rsDataT),
    .rsTagO(rsTagO), .rsTagT(rsTagT), .rsDestTag(rsDestTag)
`ifdef DISPATCH_STATS_EN
    , .statIssued(statIssued), .statStalls(statStalls)
`endif
  );

  always #5 clk = ~clk;

  function automatic int lowestFree();
    for (int i = 0; i < 15; i++) if (mFree[i]) return i;
    return 15;
  endfunction

  function automatic bit modelReady();
    return !rst && (!mValid || rsReady) && (decRd == 5'd0 || lowestFree() != 15);
  endfunction

  task automatic resolve(input logic [3:0] tag, input logic [31:0] data,
                         output logic [31:0] od, output logic [3:0] ot);
    if (tag == 4'd15) begin od = data; ot = 4'd15; end
    else if (ALUwrtEn && ALUwrtTag == tag) begin od = ALUwrtData; ot = 4'd15; end
    else if (LSwrtEn && LSwrtTag == tag) begin od = LSwrtData; ot = 4'd15; end
    else begin od = 32'd0; ot = tag; end
  endtask

  // Advances the model by one clock using the inputs currently driven, then clocks the DUT.
  task automatic tick();
    int  a;
    bit  acc;
    logic [31:0] d;
    logic [3:0]  t;
    a   = lowestFree();
    acc = decValid && modelReady();
`ifdef DISPATCH_STATS_EN
    if (rst) begin mIssued = 0; mStalls = 0; end
    else begin
      if (acc) mIssued++;
      if (decValid && !modelReady()) mStalls++;
    end
`endif
    if (rst) begin
      foreach (mFree[i]) mFree[i] = 1'b1;
      mValid = 0; mOp = 0; mImm = 0; mDataO = 0; mDataT = 0;
      mTagO = 4'd15; mTagT = 4'd15; mDest = 4'd15;
    end else begin
      if (acc) begin
        mValid = 1; mOp = decOp; mImm = decImm;
        resolve(regTagO, regDataO, mDataO, mTagO);
        resolve(regTagT, regDataT, mDataT, mTagT);
        mDest = (decRd != 0) ? 4'(a) : 4'd15;
        if (decRd != 0) mFree[a] = 1'b0;
      end else if (mValid) begin
        if (rsReady) mValid = 0;
        else begin
          if (mTagO != 4'd15) begin
            resolve(mTagO, mDataO, d, t);
            if (t == 4'd15) begin mDataO = d; mTagO = t; end
          end
          if (mTagT != 4'd15) begin
            resolve(mTagT, mDataT, d, t);
            if (t == 4'd15) begin mDataT = d; mTagT = t; end
          end
        end
      end
      if (ALUwrtEn && ALUwrtTag != 4'd15) mFree[ALUwrtTag] = 1'b1;
      if (LSwrtEn && LSwrtTag != 4'd15) mFree[LSwrtTag] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    decValid = 0; decOp = 0; decImm = 0; decRs1 = 0; decRs2 = 0; decRd = 0;
    regDataO = 0; regDataT = 0; regTagO = 4'd15; regTagT = 4'd15;
    ALUwrtEn = 0; LSwrtEn = 0; ALUwrtTag = 4'd15; LSwrtTag = 4'd15;
    ALUwrtData = 0; LSwrtData = 0; rsReady = 1;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1; decValid = 1; decRd = 5'd3;
    #1;
    checks++;
    if ({decReady, enWrtDec, wrtTagDec, wrtNameDec} !== {1'b0, 1'b0, 4'd15, 5'd0}) begin
      errors++;
      $display("[TB] FAIL reset_comb: got rdy=%b en=%b tag=%0d name=%0d expected 0 0 15 0",
               decReady, enWrtDec, wrtTagDec, wrtNameDec);
    end
    tick();
    rst = 0; decValid = 0;
    #1;
    checks++;
    if ({rsValid, rsOp, rsImm, rsDataO, rsDataT, rsTagO, rsTagT, rsDestTag} !==
        {1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd15, 4'd15, 4'd15}) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b tagO=%0d tagT=%0d dest=%0d dataO=%h expected 0 15 15 15 0",
               rsValid, rsTagO, rsTagT, rsDestTag, rsDataO);
    end
  endtask

  task automatic test_alloc();
    doReset();
    decValid = 1; decRd = 5'd3; decRs1 = 5'd7; decRs2 = 5'd9; decOp = 6'h11; decImm = 32'h55;
    #1;
    checks++;
    if ({enWrtDec, wrtTagDec, wrtNameDec, regNameO, regNameT} !== {1'b1, 4'd0, 5'd3, 5'd7, 5'd9}) begin
      errors++;
      $display("[TB] FAIL alloc_first: got en=%b tag=%0d name=%0d rn=%0d/%0d expected 1 0 3 7/9",
               enWrtDec, wrtTagDec, wrtNameDec, regNameO, regNameT);
    end
    tick();
    decRd = 5'd4;
    #1;
    checks++;
    if ({rsValid, rsDestTag, rsOp, rsImm} !== {1'b1, 4'd0, 6'h11, 32'h55}) begin
      errors++;
      $display("[TB] FAIL alloc_issue: got valid=%b dest=%0d op=%h imm=%h expected 1 0 11 55",
               rsValid, rsDestTag, rsOp, rsImm);
    end
    checks++;
    if (wrtTagDec !== 4'd1) begin
      errors++;
      $display("[TB] FAIL alloc_second: got tag=%0d expected 1", wrtTagDec);
    end
    tick();
    decValid = 0;
    #1;
    checks++;
    if (enWrtDec !== 1'b0 || rsDestTag !== 4'd1) begin
      errors++;
      $display("[TB] FAIL alloc_idle: got en=%b dest=%0d expected 0 1", enWrtDec, rsDestTag);
    end
  endtask

  task automatic test_exhaust();
    doReset();
    decValid = 1; rsReady = 1;
    for (int i = 0; i < 15; i++) begin
      decRd = 5'(i + 1);
      #1;
      checks++;
      if (enWrtDec !== 1'b1 || wrtTagDec !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL exhaust_alloc%0d: got en=%b tag=%0d expected 1 %0d", i, enWrtDec, wrtTagDec, i);
      end
      tick();
    end
    decRd = 5'd0;
    #1;
    checks++;
    if (decReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL exhaust_rd0: got rdy=%b expected 1", decReady);
    end
    decRd = 5'd5; ALUwrtEn = 1; ALUwrtTag = 4'd7;
    #1;
    checks++;
    if (decReady !== 1'b0 || enWrtDec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exhaust_stall: got rdy=%b en=%b expected 0 0", decReady, enWrtDec);
    end
    tick();
    ALUwrtEn = 0;
    #1;
    checks++;
    if (decReady !== 1'b1 || wrtTagDec !== 4'd7) begin
      errors++;
      $display("[TB] FAIL exhaust_reuse: got rdy=%b tag=%0d expected 1 7", decReady, wrtTagDec);
    end
    tick();
    decValid = 0;
    #1;
    checks++;
    if (rsDestTag !== 4'd7) begin
      errors++;
      $display("[TB] FAIL exhaust_dest: got dest=%0d expected 7", rsDestTag);
    end
  endtask

  task automatic test_bypass();
    doReset();
    decValid = 1; decRd = 5'd1; regTagO = 4'd2; regTagT = 4'd15; regDataT = 32'hCAFE;
    LSwrtEn = 1; LSwrtTag = 4'd2; LSwrtData = 32'hDEAD;
    tick();
    LSwrtEn = 0;
    checks++;
    if ({rsDataO, rsTagO, rsDataT, rsTagT} !== {32'hDEAD, 4'd15, 32'hCAFE, 4'd15}) begin
      errors++;
      $display("[TB] FAIL bypass_ls: got O=%h/%0d T=%h/%0d expected dead/15 cafe/15",
               rsDataO, rsTagO, rsDataT, rsTagT);
    end
    regTagO = 4'd9; regTagT = 4'd6;
    ALUwrtEn = 1; ALUwrtTag = 4'd9; ALUwrtData = 32'hA;
    LSwrtEn = 1; LSwrtTag = 4'd9; LSwrtData = 32'hB;
    tick();
    ALUwrtEn = 0; LSwrtEn = 0; decValid = 0;
    checks++;
    if ({rsDataO, rsTagO, rsDataT, rsTagT} !== {32'hA, 4'd15, 32'h0, 4'd6}) begin
      errors++;
      $display("[TB] FAIL bypass_prio: got O=%h/%0d T=%h/%0d expected a/15 0/6",
               rsDataO, rsTagO, rsDataT, rsTagT);
    end
  endtask

  task automatic test_snoop();
    doReset();
    decValid = 1; decRd = 5'd2; regTagT = 4'd5; rsReady = 0;
    tick();
    decRd = 5'd8;
    #1;
    checks++;
    if (rsTagT !== 4'd5 || decReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL snoop_hold: got tagT=%0d rdy=%b expected 5 0", rsTagT, decReady);
    end
    ALUwrtEn = 1; ALUwrtTag = 4'd5; ALUwrtData = 32'h1234;
    tick();
    ALUwrtEn = 0;
    #1;
    checks++;
    if ({rsValid, rsTagT, rsDataT, decReady} !== {1'b1, 4'd15, 32'h1234, 1'b0}) begin
      errors++;
      $display("[TB] FAIL snoop_capture: got valid=%b tagT=%0d dataT=%h rdy=%b expected 1 15 1234 0",
               rsValid, rsTagT, rsDataT, decReady);
    end
    decValid = 0; rsReady = 1;
    tick();
    checks++;
    if (rsValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL snoop_drain: got valid=%b expected 0", rsValid);
    end
  endtask

  task automatic test_rd0();
    doReset();
    decValid = 1; decRd = 5'd3;
    tick();
    decRd = 5'd0;
    #1;
    checks++;
    if (enWrtDec !== 1'b0 || decReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd0_comb: got en=%b rdy=%b expected 0 1", enWrtDec, decReady);
    end
    tick();
    decRd = 5'd6;
    #1;
    checks++;
    if (rsDestTag !== 4'd15 || wrtTagDec !== 4'd1) begin
      errors++;
      $display("[TB] FAIL rd0_unchanged: got dest=%0d nextTag=%0d expected 15 1", rsDestTag, wrtTagDec);
    end
    tick();
    decValid = 0;
  endtask

  task automatic test_release();
    doReset();
    decValid = 1;
    for (int i = 0; i < 3; i++) begin decRd = 5'(10 + i); tick(); end
    decValid = 0;
    ALUwrtEn = 1; ALUwrtTag = 4'd0; LSwrtEn = 1; LSwrtTag = 4'd2;
    tick();
    ALUwrtTag = 4'd1; LSwrtTag = 4'd1;
    tick();
    ALUwrtEn = 0; LSwrtEn = 0; decValid = 1;
    for (int i = 0; i < 4; i++) begin
      decRd = 5'(20 + i);
      #1;
      checks++;
      if (wrtTagDec !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL release_realloc%0d: got tag=%0d expected %0d", i, wrtTagDec, i);
      end
      tick();
    end
    decValid = 0;
  endtask

  task automatic test_reset_stall();
    doReset();
    decValid = 1; decRd = 5'd1;
    tick();
    tick();
    rsReady = 0; decValid = 1; decRd = 5'd2;
    tick();
    decValid = 0; rst = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if (rsValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rststall_valid: got valid=%b expected 0", rsValid);
    end
    rsReady = 1; decValid = 1;
    for (int i = 0; i < 15; i++) begin
      decRd = 5'(i + 1);
      #1;
      checks++;
      if (wrtTagDec !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL rststall_free%0d: got tag=%0d expected %0d", i, wrtTagDec, i);
      end
      tick();
    end
    decValid = 0;
  endtask

  task automatic test_random();
    bit expRdy;
    bit expEn;
    doReset();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      decValid   = $urandom_range(0, 3) != 0;
      decOp      = 6'($urandom);
      decImm     = $urandom;
      decRs1     = 5'($urandom);
      decRs2     = 5'($urandom);
      decRd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      regTagO    = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      regTagT    = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      regDataO   = $urandom;
      regDataT   = $urandom;
      ALUwrtEn   = $urandom_range(0, 1);
      LSwrtEn    = $urandom_range(0, 2) == 0;
      ALUwrtTag  = 4'($urandom_range(0, 15));
      LSwrtTag   = 4'($urandom_range(0, 15));
      ALUwrtData = $urandom;
      LSwrtData  = $urandom;
      rsReady    = $urandom_range(0, 2) != 0;
      #1;
      expRdy = modelReady();
      expEn  = decValid && expRdy && decRd != 0;
      checks++;
      if (decReady !== expRdy || enWrtDec !== expEn) begin
        errors++;
        $display("[TB] FAIL rand_hs%0d: got rdy=%b en=%b expected %b %b", n, decReady, enWrtDec, expRdy, expEn);
      end
      if (expEn) begin
        checks++;
        if (wrtTagDec !== 4'(lowestFree()) || wrtNameDec !== decRd) begin
          errors++;
          $display("[TB] FAIL rand_alloc%0d: got tag=%0d name=%0d expected %0d %0d",
                   n, wrtTagDec, wrtNameDec, lowestFree(), decRd);
        end
      end
      tick();
      checks++;
      if (rsValid !== mValid) begin
        errors++;
        $display("[TB] FAIL rand_valid%0d: got %b expected %b", n, rsValid, mValid);
      end
      if (mValid) begin
        checks++;
        if ({rsOp, rsImm, rsDataO, rsDataT, rsTagO, rsTagT, rsDestTag} !==
            {mOp, mImm, mDataO, mDataT, mTagO, mTagT, mDest}) begin
          errors++;
          $display("[TB] FAIL rand_payload%0d: got %h %h %h %h %0d %0d %0d expected %h %h %h %h %0d %0d %0d",
                   n, rsOp, rsImm, rsDataO, rsDataT, rsTagO, rsTagT, rsDestTag,
                   mOp, mImm, mDataO, mDataT, mTagO, mTagT, mDest);
        end
      end
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (statIssued !== mIssued || statStalls !== mStalls) begin
      errors++;
      $display("[TB] FAIL rand_stats: got issued=%0d stalls=%0d expected %0d %0d",
               statIssued, statStalls, mIssued, mStalls);
    end
`endif
  endtask

  initial begin
    clearInputs();
    rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_alloc();
    test_exhaust();
    test_bypass();
    test_snoop();
    test_rd0();
    test_release();
    test_reset_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning tag width; value 2^TAG_W-1 (15) is tagFree, tags 0..14 allocatable.
REQ-002 SHALL have parameter DATA_W, default 32, meaning operand/data width; NAME_W fixed at 5.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 decValid/decReady  input/output  1/1  decoder handshake; transfer when both high at a clock edge.
REQ-006 decOp input 6, decImm input DATA_W, decRs1/decRs2/decRd input 5 each  decoded fields.
REQ-007 regNameO/regNameT  output  5  register read names, combinationally equal to decRs1/decRs2.
REQ-008 regDataO/regDataT input DATA_W, regTagO/regTagT input TAG_W  register file read results (bypassed).
REQ-009 enWrtDec output 1, wrtTagDec output TAG_W, wrtNameDec output 5  destination tag rename to register file.
REQ-010 ALUwrtEn, LSwrtEn input 1 each; ALUwrtTag, LSwrtTag input TAG_W; ALUwrtData, LSwrtData input DATA_W  result broadcasts.
REQ-011 rsValid/rsReady  output/input  1/1  issue handshake to reservation station.
REQ-012 rsOp 6, rsImm DATA_W, rsDataO/rsDataT DATA_W, rsTagO/rsTagT TAG_W, rsDestTag TAG_W  all outputs, registered issue payload.

Function
REQ-013 SHALL keep a 15-bit free bitmap; allocation picks lowest-index free tag.
REQ-014 decReady SHALL = !rst && (!rsValid || rsReady) && (decRd==0 || any tag free), combinational.
REQ-015 On accept with decRd!=0: enWrtDec=1, wrtNameDec=decRd, wrtTagDec=allocated tag, same cycle; bitmap bit cleared at the edge.
REQ-016 On accept with decRd==0: enWrtDec=0, no allocation, rsDestTag=tagFree.
REQ-017 enWrtDec SHALL be 0 in any cycle without accept.
REQ-018 Operand capture on accept, per operand: regTag==tagFree -> data=regData, tag=tagFree; else broadcast (ALU priority over LS) with matching tag same cycle -> data=broadcast, tag=tagFree; else data=0, tag=regTag.
REQ-019 Accept SHALL load the issue register and set rsValid=1 next cycle (latency 1); rsValid clears at edge with rsReady && !accept.
REQ-020 While held (rsValid && !rsReady), each waiting operand SHALL snoop broadcasts each cycle and capture matching data, tag -> tagFree.
REQ-021 Broadcast with tag!=tagFree SHALL set that bitmap bit at the edge; release effective for allocation next cycle only (no same-cycle reuse).
REQ-022 Simultaneous ALU and LS release of different tags SHALL both be freed; equal tags freed once.
REQ-023 Bitmap all zero and decRd!=0 -> decReady=0, no state change (stall); decRd==0 still accepted.

Reset
REQ-024 rst high at an edge SHALL set bitmap all ones, rsValid=0, payload registers 0, tag fields tagFree; overrides any accept/release that cycle.
REQ-025 While rst high, decReady=0, enWrtDec=0, wrtTagDec=tagFree, wrtNameDec=0.
REQ-026 Reset mid-stall SHALL discard the held issue entry without issuing.

Configuration
REQ-027 Macro DISPATCH_STATS_EN defined: 32-bit outputs statIssued (accepts) and statStalls (cycles decValid && !decReady), saturating, reset to 0.
REQ-028 Macro undefined: those ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-029 Reset, then accept rd=3 -> enWrtDec=1, wrtTagDec=0 same cycle; next cycle rsValid=1, rsDestTag=0; second rd=4 gets tag 1.
REQ-030 Accept 15 instr with rd!=0, rsReady=1 -> 16th with rd=5 sees decReady=0; ALUwrtEn tag 7 -> next cycle 16th accepted, gets tag 7.
REQ-031 regTagO=2 and LSwrtEn tag 2 data 0xDEAD same cycle as accept -> rsDataO=0xDEAD, rsTagO=15.
REQ-032 rsReady=0 holding rsTagT=5; ALUwrtEn tag 5 data 0x1234 -> next cycle rsTagT=15, rsDataT=0x1234; decReady stays 0.
REQ-033 rd=0 accept -> enWrtDec=0, bitmap unchanged, rsDestTag=15.
REQ-034 rst asserted with rsValid=1, rsReady=0 -> next cycle rsValid=0, all 15 tags free.
